// File: rtl/step_counter_pkg.sv
// Shared types and constants for the step_counter block.
package step_counter_pkg;

    localparam int unsigned DEF_W = 16;
    localparam logic [DEF_W-1:0] DEF_MOD_MAX = {DEF_W{1'b1}};
    localparam int unsigned MAX_W = 32;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    // Number of legal count values (MOD_MAX + 1), one bit wider than the count.
    function automatic logic [MAX_W:0] mod_span(input logic [MAX_W-1:0] mod_max);
        return {1'b0, mod_max} + {{MAX_W{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/step_counter_if.sv
// Control/load/status bundle of step_counter; the counter owns the slave side.
interface step_counter_if #(
    parameter int unsigned W = 16
);
    logic         en;
    logic         up;
    logic [W-1:0] step;
    logic         clr;
    logic         ld_valid;
    logic [W-1:0] ld_data;
    logic         ld_ready;
    logic [W-1:0] cnt;
    logic         tc;
    logic         ovf;

    modport master (
        output en, up, step, clr, ld_valid, ld_data,
        input  ld_ready, cnt, tc, ovf
    );

    modport slave (
        input  en, up, step, clr, ld_valid, ld_data,
        output ld_ready, cnt, tc, ovf
    );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell used by the ripple datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/step_counter_chk.sv
// Runtime checks on step_counter inputs: an applied count step must not exceed MOD_MAX.
module step_counter_chk #(
    parameter int unsigned W = 16,
    parameter logic [W-1:0] MOD_MAX = {W{1'b1}}
) (
    input logic         clk,
    input logic         rst_n,
    input logic         en_i,
    input logic         clr_i,
    input logic         ld_acc_i,
    input logic [W-1:0] step_i
);
    a_step_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (en_i && !clr_i && !ld_acc_i) |-> (step_i <= MOD_MAX));
endmodule

// File: rtl/step_counter_ripple_add.sv
// ripple_add_n: W-bit ripple-carry adder chained from full_adder cells.
module ripple_add_n #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c_s;

    assign c_s[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c_s[i]),
            .sum  (sum[i]),
            .cout (c_s[i+1])
        );
    end

    assign cout = c_s[W];
endmodule

// File: rtl/step_counter.sv
// Modulo up/down counter with programmable step, load handshake and terminal-count flags.
// Define STEP_COUNTER_SAT_EN to saturate at 0/MOD_MAX instead of wrapping.
module step_counter
    import step_counter_pkg::*;
#(
    parameter int unsigned W = DEF_W,
    parameter logic [W-1:0] MOD_MAX = {W{1'b1}},
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input logic           clk,
    input logic           rst_n,
    step_counter_if.slave bus
);
    localparam logic [MAX_W:0] SPAN_FULL = mod_span(MAX_W'(MOD_MAX));
    localparam logic [W:0]     SPAN      = SPAN_FULL[W:0];
    localparam logic [W-1:0]   SPAN_LO   = SPAN[W-1:0];

    dir_e         dir_s;
    logic         ld_acc_s;
    logic [W-1:0] raw_b_s, raw_sum_s, fix_b_s, fix_sum_s;
    logic         raw_cin_s, raw_cout_s, fix_cin_s, fix_cout_s;
    logic         wrap_s;
    logic [W-1:0] cnt_q, cnt_d;
    logic         tc_q, tc_d, ovf_q, ovf_d, ld_ready_q;

    assign dir_s    = dir_e'(bus.up);
    assign ld_acc_s = bus.ld_valid & ld_ready_q;

    // Going down adds ~step with carry-in 1; carry-out then means "no borrow".
    assign raw_b_s   = (dir_s == DIR_UP) ? bus.step : ~bus.step;
    assign raw_cin_s = (dir_s == DIR_UP) ? 1'b0 : 1'b1;

    ripple_add_n #(.W(W)) u_raw (
        .a    (cnt_q),
        .b    (raw_b_s),
        .cin  (raw_cin_s),
        .sum  (raw_sum_s),
        .cout (raw_cout_s)
    );

    // Fold back into range: subtract the span after an up wrap, add it after a down wrap.
    assign fix_b_s   = (dir_s == DIR_UP) ? ~SPAN_LO : SPAN_LO;
    assign fix_cin_s = (dir_s == DIR_UP) ? 1'b1 : 1'b0;

    ripple_add_n #(.W(W)) u_fix (
        .a    (raw_sum_s),
        .b    (fix_b_s),
        .cin  (fix_cin_s),
        .sum  (fix_sum_s),
        .cout (fix_cout_s)
    );

    // Full range (SPAN[W] set) wraps exactly on the raw carry; otherwise sum >= span also wraps.
    assign wrap_s = (dir_s == DIR_UP) ? (raw_cout_s | (fix_cout_s & ~SPAN[W])) : ~raw_cout_s;

    // Next-state selection in priority order clr > load > count > hold.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (bus.clr) begin
            cnt_d = RST_VAL;
            ovf_d = 1'b0;
        end else if (ld_acc_s) begin
            cnt_d = (bus.ld_data > MOD_MAX) ? MOD_MAX : bus.ld_data;
        end else if (bus.en) begin
            if (wrap_s) begin
`ifdef STEP_COUNTER_SAT_EN
                cnt_d = (dir_s == DIR_UP) ? MOD_MAX : {W{1'b0}};
`else
                cnt_d = fix_sum_s;
`endif
                tc_d  = 1'b1;
                ovf_d = 1'b1;
            end else begin
                cnt_d = raw_sum_s;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= RST_VAL;
            tc_q       <= 1'b0;
            ovf_q      <= 1'b0;
            ld_ready_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tc_q       <= tc_d;
            ovf_q      <= ovf_d;
            ld_ready_q <= 1'b1;
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.tc       = tc_q;
    assign bus.ovf      = ovf_q;
    assign bus.ld_ready = ld_ready_q;

    step_counter_chk #(.W(W), .MOD_MAX(MOD_MAX)) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (bus.en),
        .clr_i    (bus.clr),
        .ld_acc_i (ld_acc_s),
        .step_i   (bus.step)
    );
endmodule

// File: tb/tb_step_counter.sv
// Bench for step_counter: a full-range 16-bit instance and a W=4, MOD_MAX=9 instance.
module tb_step_counter;
    localparam longint MODA = 65535;
    localparam longint MODB = 9;
`ifdef STEP_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    step_counter_if #(.W(16)) ifa ();
    step_counter_if #(.W(4))  ifb ();

    step_counter #(.W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    step_counter #(.W(4), .MOD_MAX(4'd9), .RST_VAL(4'd0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the counting rules.
    typedef struct { longint cnt; bit tc; bit ovf; bit rdy; } mst_t;

    function automatic mst_t mstep(mst_t s, longint md, bit rstn, bit clr, bit ldv,
                                   longint ldd, bit en, bit up, longint st);
        mst_t n;
        longint t;
        n = s;
        n.tc = 1'b0;
        if (!rstn) begin
            n.cnt = 0; n.ovf = 1'b0; n.rdy = 1'b0;
            return n;
        end
        n.rdy = 1'b1;
        if (clr) begin
            n.cnt = 0; n.ovf = 1'b0;
        end else if (ldv && s.rdy) begin
            n.cnt = (ldd > md) ? md : ldd;
        end else if (en) begin
            t = up ? s.cnt + st : s.cnt - st;
            if (t > md || t < 0) begin
                n.tc = 1'b1; n.ovf = 1'b1;
                if (SAT) n.cnt = up ? md : 0;
                else     n.cnt = up ? t - (md + 1) : t + (md + 1);
            end else begin
                n.cnt = t;
            end
        end
        return n;
    endfunction

    typedef struct { int clr; int ldv; int ldd; int en; int up; int st;
                     int cw; int tw; int cs; int ts; int ov; } vec_t;
    localparam int NV = 15;
    vec_t tbl[NV];

    task automatic idle_all();
        ifa.en = 1'b0; ifa.up = 1'b0; ifa.step = 16'd0; ifa.clr = 1'b0;
        ifa.ld_valid = 1'b0; ifa.ld_data = 16'd0;
        ifb.en = 1'b0; ifb.up = 1'b0; ifb.step = 4'd0; ifb.clr = 1'b0;
        ifb.ld_valid = 1'b0; ifb.ld_data = 4'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mst_t ma, mb;
        //           clr ldv ldd en up st | wrap cnt,tc | sat cnt,tc | ovf
        tbl[0]  = '{0, 1,  8, 0, 0, 0,  8, 0,  8, 0, 0};
        tbl[1]  = '{0, 0,  0, 1, 1, 3,  1, 1,  9, 1, 1};
        tbl[2]  = '{0, 0,  0, 0, 1, 3,  1, 0,  9, 0, 1};
        tbl[3]  = '{0, 0,  0, 1, 0, 4,  7, 1,  5, 0, 1};
        tbl[4]  = '{1, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0};
        tbl[5]  = '{1, 1,  5, 1, 1, 1,  0, 0,  0, 0, 0};
        tbl[6]  = '{0, 1,  5, 1, 1, 2,  5, 0,  5, 0, 0};
        tbl[7]  = '{0, 1, 12, 0, 0, 0,  9, 0,  9, 0, 0};
        tbl[8]  = '{0, 0,  0, 1, 1, 1,  0, 1,  9, 1, 1};
        tbl[9]  = '{0, 0,  0, 1, 0, 1,  9, 1,  8, 0, 1};
        tbl[10] = '{0, 0,  0, 1, 0, 9,  0, 0,  0, 1, 1};
        tbl[11] = '{0, 0,  0, 1, 1, 0,  0, 0,  0, 0, 1};
        tbl[12] = '{0, 0,  0, 1, 0, 0,  0, 0,  0, 0, 1};
        tbl[13] = '{0, 0,  0, 1, 1, 9,  9, 0,  9, 0, 1};
        tbl[14] = '{0, 0,  0, 1, 0, 1,  8, 0,  8, 0, 1};

        rst_n = 1'b0;
        idle_all();
        repeat (2) cyc();
        check("rst_a_cnt", ifa.cnt, 0);
        check("rst_a_tc", ifa.tc, 0);
        check("rst_a_ovf", ifa.ovf, 0);
        check("rst_a_rdy", ifa.ld_ready, 0);
        check("rst_b_cnt", ifb.cnt, 0);
        check("rst_b_rdy", ifb.ld_ready, 0);

        // First edge after release: ld_ready still low, so this load is refused.
        rst_n = 1'b1;
        ifb.ld_valid = 1'b1; ifb.ld_data = 4'd5;
        cyc();
        check("rel_b_cnt", ifb.cnt, 0);
        check("rel_a_rdy", ifa.ld_ready, 1);
        check("rel_b_rdy", ifb.ld_ready, 1);
        ifb.ld_valid = 1'b0;

        for (int i = 0; i < NV; i++) begin
            ifb.clr = (tbl[i].clr != 0);
            ifb.ld_valid = (tbl[i].ldv != 0);
            ifb.ld_data = 4'(tbl[i].ldd);
            ifb.en = (tbl[i].en != 0);
            ifb.up = (tbl[i].up != 0);
            ifb.step = 4'(tbl[i].st);
            cyc();
            check($sformatf("vec%0d_cnt", i), ifb.cnt, SAT ? tbl[i].cs : tbl[i].cw);
            check($sformatf("vec%0d_tc", i), ifb.tc, SAT ? tbl[i].ts : tbl[i].tw);
            check($sformatf("vec%0d_ovf", i), ifb.ovf, tbl[i].ov);
        end
        idle_all();

        // Full-range wrap/saturate at the top and bottom of 16 bits.
        ifa.ld_valid = 1'b1; ifa.ld_data = 16'hFFFE;
        cyc();
        check("a_ld_cnt", ifa.cnt, 16'hFFFE);
        ifa.ld_valid = 1'b0; ifa.en = 1'b1; ifa.up = 1'b1; ifa.step = 16'd5;
        cyc();
        check("a_up_cnt", ifa.cnt, SAT ? 16'hFFFF : 16'h0003);
        check("a_up_tc", ifa.tc, 1);
        check("a_up_ovf", ifa.ovf, 1);
        ifa.en = 1'b0;
        cyc();
        check("a_hold_tc", ifa.tc, 0);
        check("a_hold_ovf", ifa.ovf, 1);
        ifa.clr = 1'b1;
        cyc();
        check("a_clr_cnt", ifa.cnt, 0);
        check("a_clr_ovf", ifa.ovf, 0);
        ifa.clr = 1'b0; ifa.en = 1'b1; ifa.up = 1'b0; ifa.step = 16'd1;
        cyc();
        check("a_dn_cnt", ifa.cnt, SAT ? 16'h0000 : 16'hFFFF);
        check("a_dn_tc", ifa.tc, 1);

        // Reset asserted mid-count with load and count requests pending.
        ifa.up = 1'b1; ifa.step = 16'd3;
        ifb.en = 1'b1; ifb.up = 1'b1; ifb.step = 4'd2;
        ifb.ld_valid = 1'b1; ifb.ld_data = 4'd4;
        rst_n = 1'b0;
        cyc();
        check("mid_a_cnt", ifa.cnt, 0);
        check("mid_a_ovf", ifa.ovf, 0);
        check("mid_a_tc", ifa.tc, 0);
        check("mid_a_rdy", ifa.ld_ready, 0);
        check("mid_b_cnt", ifb.cnt, 0);
        check("mid_b_rdy", ifb.ld_ready, 0);

        // Randomized traffic against the reference model; cycle 0 keeps reset low.
        ma = '{0, 1'b0, 1'b0, 1'b0};
        mb = '{0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 600; k++) begin
            rst_n = !((k == 0) || ($urandom_range(0, 63) == 0));
            ifa.clr = ($urandom_range(0, 19) == 0);
            ifa.ld_valid = ($urandom_range(0, 7) == 0);
            ifa.ld_data = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(65520, 65535))
                                                      : 16'($urandom);
            ifa.en = ($urandom_range(0, 3) != 0);
            ifa.up = 1'($urandom_range(0, 1));
            ifa.step = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8));
            ifb.clr = ($urandom_range(0, 19) == 0);
            ifb.ld_valid = ($urandom_range(0, 7) == 0);
            ifb.ld_data = 4'($urandom_range(0, 15));
            ifb.en = ($urandom_range(0, 3) != 0);
            ifb.up = 1'($urandom_range(0, 1));
            ifb.step = 4'($urandom_range(0, 9));
            ma = mstep(ma, MODA, rst_n, ifa.clr, ifa.ld_valid, ifa.ld_data,
                       ifa.en, ifa.up, ifa.step);
            mb = mstep(mb, MODB, rst_n, ifb.clr, ifb.ld_valid, ifb.ld_data,
                       ifb.en, ifb.up, ifb.step);
            cyc();
            check($sformatf("rnd%0d_a_cnt", k), ifa.cnt, ma.cnt);
            check($sformatf("rnd%0d_a_tc", k), ifa.tc, ma.tc);
            check($sformatf("rnd%0d_a_ovf", k), ifa.ovf, ma.ovf);
            check($sformatf("rnd%0d_a_rdy", k), ifa.ld_ready, ma.rdy);
            check($sformatf("rnd%0d_b_cnt", k), ifb.cnt, mb.cnt);
            check($sformatf("rnd%0d_b_tc", k), ifb.tc, mb.tc);
            check($sformatf("rnd%0d_b_ovf", k), ifb.ovf, mb.ovf);
            check($sformatf("rnd%0d_b_rdy", k), ifb.ld_ready, mb.rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/step_counter.md
Name: step_counter

Overview:
- Parametrised modulo up/down counter with programmable step and a load handshake.
- Successor to the fixed 16-bit +1 incrementer.
- The datapath is a parametrised ripple adder built from the existing full_adder cell.
- Used as a general address/event counter wherever a wrap-aware count with terminal-count signalling is needed.

Parameters:
W, 16, counter and step width in bits
MOD_MAX, 2**W-1, highest legal count value; count range is 0..MOD_MAX (must satisfy 1 <= MOD_MAX <= 2**W-1)
RST_VAL, 0, value of cnt after reset (must be <= MOD_MAX)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  synchronous active-low reset
en  input  1  count enable
up  input  1  direction: 1 = add step, 0 = subtract step
step  input  W  increment magnitude (legal range 1..MOD_MAX; step = 0 holds the value)
clr  input  1  synchronous clear to RST_VAL
ld_valid  input  1  load request
ld_data  input  W  load value
ld_ready  output  1  load acceptance
cnt  output  W  current count, registered
tc  output  1  one-cycle pulse when a count step wraps (or saturates)
ovf  output  1  sticky wrap/saturate flag

Behaviour:
- All state updates on the rising edge of clk. rst_n is sampled only on the edge.
- Reset (rst_n = 0 at an edge) gives: cnt = RST_VAL, tc = 0, ovf = 0, ld_ready = 0.
- ld_ready is a register loaded with 1 on the first edge with rst_n = 1. It therefore stays low for exactly one cycle after reset release, then remains high.
- A load is accepted when ld_valid & ld_ready on a clock edge.
- Priority per edge: reset > clr > accepted load > count > hold.
- clr:
  - cnt = RST_VAL, tc = 0, ovf = 0.
  - A simultaneous load or count is dropped.
- Accepted load:
  - cnt = ld_data if ld_data <= MOD_MAX, else cnt = MOD_MAX (clamped).
  - tc = 0; ovf is unchanged.
  - en is ignored that cycle.
- Count (en = 1, no clr, no accepted load):
  - Sum is computed in W+1 bits by the ripple adder.
  - up = 1: s = cnt + step.
    - If s > MOD_MAX: cnt = s - (MOD_MAX + 1), tc = 1, ovf = 1.
    - Else: cnt = s, tc = 0.
  - up = 0: if cnt >= step, cnt = cnt - step, tc = 0.
    - Else: cnt = cnt + (MOD_MAX + 1) - step, tc = 1, ovf = 1.
  - Subtraction is implemented as add of the two's complement, with the carry-in set to 1.
- Hold (en = 0): cnt unchanged, tc = 0.
- tc is registered: it is high in the cycle after the wrapping edge, for one cycle only. A back-to-back wrap keeps tc high on consecutive cycles.
- ovf: set by any wrap; cleared only by reset or clr.
- Latency: one clock from en/ld to the updated cnt. No combinational path from inputs to outputs.
- Boundary cases:
  - Count at MOD_MAX with up = 1, step = 1: cnt = 0.
  - Count at 0 with up = 0, step = 1: cnt = MOD_MAX.
  - MOD_MAX = 2**W-1: wrap equals natural modulo 2**W, detected by the carry out of bit W-1.
  - step > MOD_MAX is illegal. The bench must not drive it; an assertion flags it.
  - Reset asserted mid-count: cnt returns to RST_VAL on that edge, regardless of en, ld or clr.

Optional Feature:
Macro STEP_COUNTER_SAT_EN.
- Defined: saturating mode.
  - up overflow gives cnt = MOD_MAX; down underflow gives cnt = 0.
  - tc pulses and ovf sets exactly as for a wrap.
  - A count already at the bound with en = 1 re-saturates, pulsing tc each cycle.
- Not defined: wrap behaviour as described in Behaviour.

Decomposition:
- Package step_counter_pkg:
  - Localparams for default W/MOD_MAX.
  - Function to compute MOD_MAX+1 in W+1 bits.
  - Enum type for direction (DIR_DN = 0, DIR_UP = 1).
- Sub-module ripple_add_n: parametrised W-bit ripple-carry adder.
  - Generate loop of full_adder instances.
  - Ports a, b, cin, sum, cout.
  - Two instances: raw sum/difference, and wrap correction.

Test Plan:
- Reset, default params: rst_n = 0 two cycles, then release.
  - Required: cnt = 0, ovf = 0, ld_ready = 0 the first cycle after release and 1 thereafter.
- Up wrap, MOD_MAX = 9: ld_data = 8, then en = 1, up = 1, step = 3.
  - Required: cnt = 1, tc high one cycle, ovf = 1.
- Down wrap, MOD_MAX = 9: cnt = 1, up = 0, step = 4.
  - Required: cnt = 7, tc pulse, ovf = 1; then clr gives cnt = 0, ovf = 0.
- Priority: same edge has clr = 1, ld_valid = 1 (ld_data = 5), en = 1.
  - Required: cnt = RST_VAL.
  - Next edge, ld_valid = 1, en = 1: cnt = 5.
- Load clamp, MOD_MAX = 9: ld_data = 12.
  - Required: cnt = 9, tc = 0.
- STEP_COUNTER_SAT_EN, W = 16, full range: cnt = 16'hFFFE, up, step = 5.
  - Required: cnt = 16'hFFFF, tc = 1.
  - Without the macro: cnt = 16'h0003, tc = 1.
